// File: rtl/ipq_fetch_unit.sv
`default_nettype none
// ipq_fetch_unit: assembles one instruction (prefixes, opcode, ModRM, disp, imm)
// from the BCU prefetch queue and performs queue flush/retarget on branches.
module ipq_fetch_unit (
   input  logic            clk,
   input  logic            reset,
   input  logic            ce_1_i,
   input  logic            ce_2_i,
   input  logic [7:0][7:0] ipq_i,
   input  logic [3:0]      ipq_len_i,
   output logic [15:0]     ipq_head_o,
   output logic            pfp_set_o,
   input  logic            modrm_needed_i,
   input  logic [1:0]      imm_bytes_i,
   input  logic            branch_i,
   input  logic [15:0]     branch_target_i,
   output logic            insn_valid_o,
   input  logic            insn_accept_i,
   output logic [15:0]     insn_ip_o,
   output logic [3:0]      insn_len_o,
   output logic            seg_ovr_valid_o,
   output logic [1:0]      seg_ovr_o,
   output logic [1:0]      rep_o,
   output logic            lock_o,
   output logic            ext_o,
   output logic [7:0]      opcode_o,
   output logic [7:0]      modrm_o,
   output logic [15:0]     disp_o,
   output logic [15:0]     imm_o
);

   typedef enum logic [2:0] {
      S_PREFIX  = 3'd0,
      S_OP2     = 3'd1,
      S_MODRM   = 3'd2,
      S_DISP_LO = 3'd3,
      S_DISP_HI = 3'd4,
      S_IMM_LO  = 3'd5,
      S_IMM_HI  = 3'd6,
      S_HOLD    = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic        eval_q, eval_d;
   logic        disp2_q, disp2_d;
   logic        imm2_q, imm2_d;
   logic [15:0] head_q, head_d;
   logic        pfp_q, pfp_d;
   logic [15:0] ip_q, ip_d;
   logic [3:0]  len_q, len_d;
   logic        segv_q, segv_d;
   logic [1:0]  seg_q, seg_d;
   logic [1:0]  rep_q, rep_d;
   logic        lock_q, lock_d;
   logic        ext_q, ext_d;
   logic [7:0]  op_q, op_d;
   logic [7:0]  modrm_q, modrm_d;
   logic [15:0] disp_q, disp_d;
   logic [15:0] imm_q, imm_d;

   logic [7:0]  w_byte;
   logic        w_take;
   logic        w_clear;
   state_t      w_imm_state;
   logic        unused_ce_2;

   assign unused_ce_2 = ce_2_i;

   always_comb begin
      state_d = state_q;
      eval_d  = eval_q;
      disp2_d = disp2_q;
      imm2_d  = imm2_q;
      head_d  = head_q;
      pfp_d   = branch_i;
      ip_d    = ip_q;
      len_d   = len_q;
      segv_d  = segv_q;
      seg_d   = seg_q;
      rep_d   = rep_q;
      lock_d  = lock_q;
      ext_d   = ext_q;
      op_d    = op_q;
      modrm_d = modrm_q;
      disp_d  = disp_q;
      imm_d   = imm_q;
      w_clear = 1'b0;
      w_byte  = ipq_i[head_q[2:0]];
      // A pending opcode evaluation never consumes a byte
      w_take  = (state_q != S_HOLD) && !eval_q && (ipq_len_i != 4'd0) && !pfp_q && !branch_i;
      w_imm_state = (imm_bytes_i == 2'd0) ? S_HOLD : S_IMM_LO;

      if (w_take) begin
         head_d = head_q + 16'd1;
         if (len_q != 4'hF) len_d = len_q + 4'd1;
      end

      case (state_q)
         S_PREFIX: begin
            if (w_take) begin
               if (len_q == 4'd0) ip_d = head_q;
               case (w_byte)
                  8'h26, 8'h2E, 8'h36, 8'h3E: begin
                     segv_d = 1'b1;
                     seg_d  = w_byte[4:3];
                  end
                  8'hF2: rep_d  = 2'd1;
                  8'hF3: rep_d  = 2'd2;
                  8'hF0: lock_d = 1'b1;
                  8'h0F: begin
                     ext_d   = 1'b1;
                     state_d = S_OP2;
                  end
                  default: begin
                     op_d    = w_byte;
                     eval_d  = 1'b1;
                     state_d = S_MODRM;
                  end
               endcase
            end
         end
         S_OP2: begin
            if (w_take) begin
               op_d    = w_byte;
               eval_d  = 1'b1;
               state_d = S_MODRM;
            end
         end
         S_MODRM: begin
            if (eval_q) begin
               eval_d = 1'b0;
               if (!modrm_needed_i) begin
                  imm2_d  = imm_bytes_i[1];
                  state_d = w_imm_state;
               end
            end else if (w_take) begin
               modrm_d = w_byte;
               if (w_byte[7:6] == 2'b00 && w_byte[2:0] == 3'b110) begin
                  disp2_d = 1'b1;
                  state_d = S_DISP_LO;
               end else if (w_byte[7:6] == 2'b01) begin
                  disp2_d = 1'b0;
                  state_d = S_DISP_LO;
               end else if (w_byte[7:6] == 2'b10) begin
                  disp2_d = 1'b1;
                  state_d = S_DISP_LO;
               end else begin
                  imm2_d  = imm_bytes_i[1];
                  state_d = w_imm_state;
               end
            end
         end
         S_DISP_LO: begin
            if (w_take) begin
               disp_d = {{8{w_byte[7]}}, w_byte};
               if (disp2_q) begin
                  state_d = S_DISP_HI;
               end else begin
                  imm2_d  = imm_bytes_i[1];
                  state_d = w_imm_state;
               end
            end
         end
         S_DISP_HI: begin
            if (w_take) begin
               disp_d[15:8] = w_byte;
               imm2_d       = imm_bytes_i[1];
               state_d      = w_imm_state;
            end
         end
         S_IMM_LO: begin
            if (w_take) begin
               imm_d   = {8'h00, w_byte};
               state_d = imm2_q ? S_IMM_HI : S_HOLD;
            end
         end
         S_IMM_HI: begin
            if (w_take) begin
               imm_d[15:8] = w_byte;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (insn_accept_i) begin
               w_clear = 1'b1;
               state_d = S_PREFIX;
            end
         end
         default: state_d = S_PREFIX;
      endcase

      // Branch wins over accept and over any fetch in the same ce_1
      if (branch_i) begin
         head_d  = branch_target_i;
         w_clear = 1'b1;
         state_d = S_PREFIX;
      end

      if (w_clear) begin
         eval_d  = 1'b0;
         disp2_d = 1'b0;
         imm2_d  = 1'b0;
         ip_d    = 16'd0;
         len_d   = 4'd0;
         segv_d  = 1'b0;
         seg_d   = 2'd0;
         rep_d   = 2'd0;
         lock_d  = 1'b0;
         ext_d   = 1'b0;
         op_d    = 8'd0;
         modrm_d = 8'd0;
         disp_d  = 16'd0;
         imm_d   = 16'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_PREFIX;
         eval_q  <= 1'b0;
         disp2_q <= 1'b0;
         imm2_q  <= 1'b0;
         head_q  <= 16'd0;
         pfp_q   <= 1'b0;
         ip_q    <= 16'd0;
         len_q   <= 4'd0;
         segv_q  <= 1'b0;
         seg_q   <= 2'd0;
         rep_q   <= 2'd0;
         lock_q  <= 1'b0;
         ext_q   <= 1'b0;
         op_q    <= 8'd0;
         modrm_q <= 8'd0;
         disp_q  <= 16'd0;
         imm_q   <= 16'd0;
      end else if (ce_1_i) begin
         state_q <= state_d;
         eval_q  <= eval_d;
         disp2_q <= disp2_d;
         imm2_q  <= imm2_d;
         head_q  <= head_d;
         pfp_q   <= pfp_d;
         ip_q    <= ip_d;
         len_q   <= len_d;
         segv_q  <= segv_d;
         seg_q   <= seg_d;
         rep_q   <= rep_d;
         lock_q  <= lock_d;
         ext_q   <= ext_d;
         op_q    <= op_d;
         modrm_q <= modrm_d;
         disp_q  <= disp_d;
         imm_q   <= imm_d;
      end
   end

   assign ipq_head_o      = head_q;
   assign pfp_set_o       = pfp_q;
   assign insn_valid_o    = (state_q == S_HOLD);
   assign insn_ip_o       = ip_q;
   assign insn_len_o      = len_q;
   assign seg_ovr_valid_o = segv_q;
   assign seg_ovr_o       = seg_q;
   assign rep_o           = rep_q;
   assign lock_o          = lock_q;
   assign ext_o           = ext_q;
   assign opcode_o        = op_q;
   assign modrm_o         = modrm_q;
   assign disp_o          = disp_q;
   assign imm_o           = imm_q;

endmodule
`default_nettype wire

// File: tb/tb_ipq_fetch_unit.sv
`default_nettype none
// tb_ipq_fetch_unit: table-driven instruction vectors with a scoreboard queue,
// plus hand sequences for stall, branch, branch-vs-accept and IP wrap.
module tb_ipq_fetch_unit;

   logic            clk = 1'b0;
   logic            reset;
   logic            ce_1, ce_2;
   logic [7:0][7:0] ipq;
   logic [3:0]      ipq_len;
   logic [15:0]     ipq_head;
   logic            pfp_set;
   logic            modrm_needed;
   logic [1:0]      imm_bytes;
   logic            branch;
   logic [15:0]     branch_target;
   logic            insn_valid;
   logic            insn_accept;
   logic [15:0]     insn_ip;
   logic [3:0]      insn_len;
   logic            seg_ovr_valid;
   logic [1:0]      seg_ovr;
   logic [1:0]      rep;
   logic            lock;
   logic            ext;
   logic [7:0]      opcode;
   logic [7:0]      modrm;
   logic [15:0]     disp;
   logic [15:0]     imm;

   ipq_fetch_unit dut (
      .clk(clk), .reset(reset), .ce_1_i(ce_1), .ce_2_i(ce_2),
      .ipq_i(ipq), .ipq_len_i(ipq_len), .ipq_head_o(ipq_head), .pfp_set_o(pfp_set),
      .modrm_needed_i(modrm_needed), .imm_bytes_i(imm_bytes),
      .branch_i(branch), .branch_target_i(branch_target),
      .insn_valid_o(insn_valid), .insn_accept_i(insn_accept),
      .insn_ip_o(insn_ip), .insn_len_o(insn_len),
      .seg_ovr_valid_o(seg_ovr_valid), .seg_ovr_o(seg_ovr), .rep_o(rep),
      .lock_o(lock), .ext_o(ext), .opcode_o(opcode), .modrm_o(modrm),
      .disp_o(disp), .imm_o(imm)
   );

   always #5 clk = ~clk;

   // BCU model: memory image, queue window starting at ipq_head, fill limit lim
   logic [7:0]  mem [0:65535];
   logic [15:0] lim;
   logic [15:0] rem;
   logic [15:0] qa;

   always_comb begin
      rem     = lim - ipq_head;
      ipq_len = pfp_set ? 4'd0 : ((rem > 16'd8) ? 4'd8 : rem[3:0]);
      ipq     = '0;
      qa      = 16'd0;
      for (int k = 0; k < 8; k++) begin
         qa = ipq_head + 16'(k);
         ipq[qa[2:0]] = mem[qa];
      end
   end

   typedef struct {
      logic [127:0] bytes;
      int           n;
      logic         mn;
      logic [1:0]   ib;
      int           lat;
      logic         sv;
      logic [1:0]   so;
      logic [1:0]   rp;
      logic         lk;
      logic         ex;
      logic [7:0]   op;
      logic [7:0]   mr;
      logic [15:0]  dsp;
      logic [15:0]  im;
      logic [3:0]   len;
   } vec_t;

   vec_t        vecs[11];
   vec_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_head;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic ce_cycle();
      ce_1 = 1'b0; ce_2 = 1'b1;
      @(posedge clk); #1;
      ce_1 = 1'b1; ce_2 = 1'b0;
      @(posedge clk); #1;
      ce_1 = 1'b0; ce_2 = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      logic [15:0] start;
      logic [15:0] a;
      vec_t        e;
      int          cnt;
      start = exp_head;
      for (int k = 0; k < v.n; k++) begin
         a = start + 16'(k);
         mem[a] = v.bytes[8*k +: 8];
      end
      modrm_needed = v.mn;
      imm_bytes    = v.ib;
      sb.push_back(v);
      lim = start + 16'(v.n);
      cnt = 0;
      while (!insn_valid && cnt < 60) begin
         ce_cycle();
         cnt++;
      end
      chk("insn_valid", {31'd0, insn_valid}, 32'd1);
      e = sb.pop_front();
      chk("latency", cnt, e.lat);
      chk("insn_ip", {16'd0, insn_ip}, {16'd0, start});
      chk("ipq_head", {16'd0, ipq_head}, {16'd0, start + 16'(e.n)});
      chk("insn_len", {28'd0, insn_len}, {28'd0, e.len});
      chk("seg_ovr_valid", {31'd0, seg_ovr_valid}, {31'd0, e.sv});
      chk("seg_ovr", {30'd0, seg_ovr}, {30'd0, e.so});
      chk("rep", {30'd0, rep}, {30'd0, e.rp});
      chk("lock", {31'd0, lock}, {31'd0, e.lk});
      chk("ext", {31'd0, ext}, {31'd0, e.ex});
      chk("opcode", {24'd0, opcode}, {24'd0, e.op});
      chk("modrm", {24'd0, modrm}, {24'd0, e.mr});
      chk("disp", {16'd0, disp}, {16'd0, e.dsp});
      chk("imm", {16'd0, imm}, {16'd0, e.im});
      exp_head = start + 16'(e.n);
      insn_accept = 1'b1;
      ce_cycle();
      insn_accept = 1'b0;
      chk("accept_valid", {31'd0, insn_valid}, 32'd0);
      chk("accept_clr", {20'd0, insn_len, opcode}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      lim = 16'd0;
      reset = 1'b1; ce_1 = 1'b0; ce_2 = 1'b0;
      modrm_needed = 1'b0; imm_bytes = 2'd0;
      branch = 1'b0; branch_target = 16'd0; insn_accept = 1'b0;
      exp_head = 16'd0;

      //            bytes (byte0 in LSB)         n  mn ib  lat sv so rp lk ex op     mr     disp      imm       len
      vecs[0]  = '{128'h90,                       1, 0, 0,  2, 0, 0, 0, 0, 0, 8'h90, 8'h00, 16'h0000, 16'h0000, 4'd1};
      vecs[1]  = '{128'hA5F32E,                   3, 0, 0,  4, 1, 1, 2, 0, 0, 8'hA5, 8'h00, 16'h0000, 16'h0000, 4'd3};
      vecs[2]  = '{128'h1234868B,                 4, 1, 0,  5, 0, 0, 0, 0, 0, 8'h8B, 8'h86, 16'h1234, 16'h0000, 4'd4};
      vecs[3]  = '{128'h05FE4683,                 4, 1, 1,  5, 0, 0, 0, 0, 0, 8'h83, 8'h46, 16'hFFFE, 16'h0005, 4'd4};
      vecs[4]  = '{128'hC1100F,                   3, 1, 0,  4, 0, 0, 0, 0, 1, 8'h10, 8'hC1, 16'h0000, 16'h0000, 4'd3};
      vecs[5]  = '{128'h1234B8,                   3, 0, 2,  4, 0, 0, 0, 0, 0, 8'hB8, 8'h00, 16'h0000, 16'h1234, 4'd3};
      vecs[6]  = '{128'h5678068AF3F2F03E26,       9, 1, 0, 10, 1, 3, 2, 1, 0, 8'h8A, 8'h06, 16'h5678, 16'h0000, 4'd9};
      vecs[7]  = '{128'hAB123406C6,               5, 1, 1,  6, 0, 0, 0, 0, 0, 8'hC6, 8'h06, 16'h1234, 16'h00AB, 4'd5};
      vecs[8]  = '{128'h8004,                     2, 0, 1,  3, 0, 0, 0, 0, 0, 8'h04, 8'h00, 16'h0000, 16'h0080, 4'd2};
      vecs[9]  = '{128'h80478936,                 4, 1, 0,  5, 1, 2, 0, 0, 0, 8'h89, 8'h47, 16'hFF80, 16'h0000, 4'd4};
      vecs[10] = '{{8'h90, {15{8'h2E}}},         16, 0, 0, 17, 1, 1, 0, 0, 0, 8'h90, 8'h00, 16'h0000, 16'h0000, 4'd15};

      ce_cycle();
      ce_cycle();
      reset = 1'b0;
      #1;
      chk("reset_head", {16'd0, ipq_head}, 32'd0);
      chk("reset_ctl", {29'd0, pfp_set, insn_valid, lock}, 32'd0);
      chk("reset_fields", {insn_ip, opcode, modrm}, 32'd0);
      chk("reset_di", {disp, imm}, 32'd0);

      for (int v = 0; v < 11; v++) run_vec(vecs[v]);

      // Branch while waiting for displacement bytes
      mem[exp_head]         = 8'h8B;
      mem[exp_head + 16'd1] = 8'h86;
      lim = exp_head + 16'd2;
      modrm_needed = 1'b1; imm_bytes = 2'd0;
      for (int c = 0; c < 3; c++) ce_cycle();
      chk("pre_br_valid", {31'd0, insn_valid}, 32'd0);
      chk("pre_br_modrm", {24'd0, modrm}, 32'h86);
      branch = 1'b1; branch_target = 16'h0100;
      ce_cycle();
      branch = 1'b0;
      lim = 16'h0100;
      chk("br_pfp", {31'd0, pfp_set}, 32'd1);
      chk("br_head", {16'd0, ipq_head}, 32'h0100);
      chk("br_clear", {insn_len, 4'd0, opcode, modrm, 8'd0}, 32'd0);
      chk("br_disp_ip", {disp, insn_ip}, 32'd0);
      ce_cycle();
      chk("br_pfp_drop", {31'd0, pfp_set}, 32'd0);
      chk("br_head_hold", {16'd0, ipq_head}, 32'h0100);
      exp_head = 16'h0100;
      run_vec(vecs[0]);

      // Branch together with accept in S_HOLD
      mem[16'h0101] = 8'h90;
      lim = 16'h0102;
      modrm_needed = 1'b0; imm_bytes = 2'd0;
      ce_cycle();
      ce_cycle();
      chk("hold_valid", {31'd0, insn_valid}, 32'd1);
      branch = 1'b1; branch_target = 16'h0200; insn_accept = 1'b1;
      ce_cycle();
      branch = 1'b0; insn_accept = 1'b0;
      lim = 16'h0200;
      chk("bra_valid", {31'd0, insn_valid}, 32'd0);
      chk("bra_pfp", {31'd0, pfp_set}, 32'd1);
      chk("bra_head", {16'd0, ipq_head}, 32'h0200);
      ce_cycle();
      chk("bra_pfp_drop", {31'd0, pfp_set}, 32'd0);

      // Queue runs dry before the immediate high byte
      mem[16'h0200] = 8'hB8; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
      lim = 16'h0202;
      modrm_needed = 1'b0; imm_bytes = 2'd2;
      for (int c = 0; c < 6; c++) ce_cycle();
      chk("stall_valid", {31'd0, insn_valid}, 32'd0);
      chk("stall_imm", {16'd0, imm}, 32'h0034);
      chk("stall_head", {16'd0, ipq_head}, 32'h0202);
      lim = 16'h0203;
      ce_cycle();
      chk("unstall_valid", {31'd0, insn_valid}, 32'd1);
      chk("unstall_imm", {16'd0, imm}, 32'h1234);
      chk("unstall_len", {28'd0, insn_len}, 32'd3);
      insn_accept = 1'b1;
      ce_cycle();
      insn_accept = 1'b0;

      // Head wraps from FFFF to 0000
      branch = 1'b1; branch_target = 16'hFFFF;
      ce_cycle();
      branch = 1'b0;
      lim = 16'hFFFF;
      ce_cycle();
      chk("wrap_head0", {16'd0, ipq_head}, 32'hFFFF);
      exp_head = 16'hFFFF;
      run_vec(vecs[0]);
      chk("wrap_head", {16'd0, ipq_head}, 32'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
